bfs_run_ctrl: RTL

Top-level run sequencer for the BFS accelerator. On a software start it seeds the traversal (`init` handshake), then issues one frontier-expansion request per BFS level to the level engine until the frontier empties, a level cap is hit, software aborts, or a watchdog expires. It drives the `busy`/`done` status bits consumed by the status register block and reports a termination code and level count.

---
 rtl/bfs_run_ctrl.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/bfs_run_ctrl.sv
// BFS run sequencer: seeds the traversal, then issues one level-expansion request per BFS level
// until termination. Define BFS_RUN_CTRL_TIMEOUT_EN to build the watchdog (term_code 3).
module bfs_run_ctrl #(
  parameter int VID_W     = 32,
  parameter int LEVEL_W   = 16,
  parameter int TIMEOUT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [VID_W-1:0]     root_vid,
  input  logic [LEVEL_W-1:0]   max_level,
  input  logic [TIMEOUT_W-1:0] timeout_cycles,
  output logic                 init_req,
  output logic [VID_W-1:0]     init_root,
  input  logic                 init_ack,
  output logic                 lvl_req,
  output logic [LEVEL_W-1:0]   lvl_idx,
  input  logic                 lvl_ack,
  input  logic                 lvl_next_empty,
  output logic                 busy,
  output logic                 done,
  output logic                 done_irq,
  output logic [1:0]           term_code,
  output logic [LEVEL_W-1:0]   levels_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_LEVEL,
    S_NEXT,
    S_DRAIN,
    S_FINISH
  } state_t;

  state_t             state;
  state_t             state_n;
  logic               run;
  logic               accept;
  logic [LEVEL_W-1:0] max_lvl;
  logic               abort_pend;
  logic               abort_hit;
  logic               tmo_hit;
  logic               stop;
  logic [1:0]         stop_code;
  logic               drain_lvl;
  logic               drain_lvl_n;
  logic               ld_inc;
  logic               idx_inc;
  logic [1:0]         fin_code;

  assign run       = (state == S_INIT) || (state == S_LEVEL) ||
                     (state == S_NEXT) || (state == S_DRAIN);
  assign accept    = (state == S_IDLE) && start;
  assign abort_hit = run && (abort_pend || abort);
  assign stop      = abort_hit || tmo_hit;
  assign stop_code = abort_hit ? 2'd2 : 2'd3;

`ifdef BFS_RUN_CTRL_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_limit;
  logic [TIMEOUT_W-1:0] wd_cnt;
  logic                 tmo_pend;
  logic                 tmo_now;

  // Watchdog counts every non-idle cycle from 0; firing at limit-1 gives exactly
  // timeout_cycles cycles of run time before the stop is requested.
  assign tmo_now = run && (tmo_limit != '0) && (wd_cnt == tmo_limit - TIMEOUT_W'(1));
  assign tmo_hit = run && (tmo_pend || tmo_now);

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_limit <= '0;
      wd_cnt    <= '0;
      tmo_pend  <= 1'b0;
    end else if (accept) begin
      tmo_limit <= timeout_cycles;
      wd_cnt    <= '0;
      tmo_pend  <= 1'b0;
    end else begin
      if (state != S_IDLE) begin
        wd_cnt <= wd_cnt + TIMEOUT_W'(1);
      end
      if (run) begin
        tmo_pend <= tmo_hit;
      end
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^timeout_cycles;
  assign tmo_hit        = 1'b0;
`endif

  always_comb begin
    state_n     = state;
    drain_lvl_n = drain_lvl;
    ld_inc      = 1'b0;
    idx_inc     = 1'b0;
    fin_code    = 2'd0;
    init_req    = 1'b0;
    lvl_req     = 1'b0;
    busy        = 1'b0;
    done_irq    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_INIT;
        end
      end
      S_INIT: begin
        busy     = 1'b1;
        init_req = 1'b1;
        if (init_ack) begin
          if (stop) begin
            state_n  = S_FINISH;
            fin_code = stop_code;
          end else begin
            state_n = S_LEVEL;
          end
        end else if (stop) begin
          state_n     = S_DRAIN;
          drain_lvl_n = 1'b0;
        end
      end
      S_LEVEL: begin
        busy    = 1'b1;
        lvl_req = 1'b1;
        if (lvl_ack) begin
          ld_inc = 1'b1;
          if (stop) begin
            state_n  = S_FINISH;
            fin_code = stop_code;
          end else if (lvl_next_empty) begin
            state_n  = S_FINISH;
            fin_code = 2'd0;
          end else if ((max_lvl != '0) && ((levels_done + LEVEL_W'(1)) == max_lvl)) begin
            state_n  = S_FINISH;
            fin_code = 2'd1;
          end else begin
            state_n = S_NEXT;
          end
        end else if (stop) begin
          state_n     = S_DRAIN;
          drain_lvl_n = 1'b1;
        end
      end
      S_NEXT: begin
        busy = 1'b1;
        if (stop) begin
          state_n  = S_FINISH;
          fin_code = stop_code;
        end else begin
          idx_inc = 1'b1;
          state_n = S_LEVEL;
        end
      end
      S_DRAIN: begin
        // The outstanding request stays up so the engine can finish cleanly.
        busy     = 1'b1;
        init_req = !drain_lvl;
        lvl_req  = drain_lvl;
        if (drain_lvl ? lvl_ack : init_ack) begin
          ld_inc   = drain_lvl;
          state_n  = S_FINISH;
          fin_code = stop_code;
        end
      end
      S_FINISH: begin
        done_irq = 1'b1;
        state_n  = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      init_root   <= '0;
      max_lvl     <= '0;
      lvl_idx     <= '0;
      levels_done <= '0;
      done        <= 1'b0;
      term_code   <= 2'd0;
      abort_pend  <= 1'b0;
      drain_lvl   <= 1'b0;
    end else begin
      state     <= state_n;
      drain_lvl <= drain_lvl_n;
      if (accept) begin
        init_root   <= root_vid;
        max_lvl     <= max_level;
        lvl_idx     <= '0;
        levels_done <= '0;
        done        <= 1'b0;
        abort_pend  <= 1'b0;
      end else begin
        if (run) begin
          abort_pend <= abort_hit;
        end
        if (ld_inc) begin
          levels_done <= levels_done + LEVEL_W'(1);
        end
        if (idx_inc) begin
          lvl_idx <= lvl_idx + LEVEL_W'(1);
        end
        if (state_n == S_FINISH) begin
          done      <= 1'b1;
          term_code <= fin_code;
        end
      end
    end
  end

endmodule
